// File: rtl/elevator_call_scheduler.sv
// -----------------------------------------------------------------------------
// elevator_call_scheduler
//
// Schedules the elevator car from the raw floor-call buttons. Each button is
// passed through a two-flop synchronizer and a rising-edge detector. Every new
// press is latched as a pending call. The car is sequenced with a LOOK policy:
// it keeps its direction while calls remain ahead of it, and otherwise it
// reverses or idles.
//
// Ports:
//   clk        in   system clock; all state changes on posedge
//   reset_n    in   asynchronous active-low reset
//   call_btn   in   [FLOORS]   raw asynchronous call buttons, bit i = floor i
//   pending    out  [FLOORS]   latched outstanding calls
//   cur_floor  out  [FLOOR_W]  current car floor
//   dir_up     out  1 = travelling/last travelled up, 0 = down
//   moving     out  high while the car travels between floors
//   door_open  out  high while the door is open
//   arrive     out  one-cycle pulse after each floor change
// -----------------------------------------------------------------------------
module elevator_call_scheduler #(
    parameter int FLOORS        = 4,
    parameter int FLOOR_W       = 2,
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [FLOORS-1:0]  call_btn,
    output logic [FLOORS-1:0]  pending,
    output logic [FLOOR_W-1:0] cur_floor,
    output logic               dir_up,
    output logic               moving,
    output logic               door_open,
    output logic               arrive
);

    // One timer serves both the travel leg and the door hold time.
    localparam int TIMER_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX);

    localparam logic [TIMER_W-1:0] TRAVEL_LAST = TIMER_W'(TRAVEL_CYCLES - 1);
    localparam logic [TIMER_W-1:0] DOOR_LAST   = TIMER_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(FLOORS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE,
        ST_DOOR
    } state_e;

    logic [FLOORS-1:0]  s1_q, s2_q, s3_q;
    logic [FLOORS-1:0]  rise;
    logic [FLOORS-1:0]  pending_q, pending_d;
    logic [FLOORS-1:0]  set_mask, clr_mask;
    logic [FLOOR_W-1:0] cur_floor_q, cur_floor_d, step_floor;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               dir_up_q, dir_up_d;
    logic               arrive_q, arrive_d;
    logic               above, below, here;
    state_e             state_q, state_d;

    // -------------------------------------------------------------------------
    // Input path: s1/s2 synchronize the asynchronous buttons, s3 holds the
    // previous synchronized level so a held button yields one call only.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the value
            // from before the edge; blocking ones here would collapse the
            // three stages into one.
            s1_q <= call_btn;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign rise = s2_q & ~s3_q;

    // -------------------------------------------------------------------------
    // Where the outstanding calls lie relative to the car.
    // -------------------------------------------------------------------------
    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (pending_q[i] && (i > int'(cur_floor_q))) above = 1'b1;
            if (pending_q[i] && (i < int'(cur_floor_q))) below = 1'b1;
        end
    end

    assign here = pending_q[cur_floor_q];

    // Next floor in the current direction, held at the shaft ends. The
    // scheduler only heads toward an existing call, so the hold is a guard.
    always_comb begin
        step_floor = cur_floor_q;
        if (dir_up_q) begin
            if (cur_floor_q != TOP_FLOOR) step_floor = cur_floor_q + FLOOR_W'(1);
        end else begin
            if (cur_floor_q != '0) step_floor = cur_floor_q - FLOOR_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. New call edges are set in pending unless the same bit
    // is cleared on this edge; the clear only happens for the floor the car is
    // serving, so "clear wins" is confined to DOOR or entry into DOOR.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the
        // case below leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        cur_floor_d = cur_floor_q;
        dir_up_d    = dir_up_q;
        timer_d     = timer_q;
        arrive_d    = 1'b0;
        set_mask    = rise;
        clr_mask    = '0;

        unique case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (here) begin
                    state_d               = ST_DOOR;
                    clr_mask[cur_floor_q] = 1'b1;
                end else if (dir_up_q && above) begin
                    state_d = ST_MOVE;
                end else if (!dir_up_q && below) begin
                    state_d = ST_MOVE;
                end else if (above) begin
                    state_d  = ST_MOVE;
                    dir_up_d = 1'b1;
                end else if (below) begin
                    state_d  = ST_MOVE;
                    dir_up_d = 1'b0;
                end
            end

            ST_MOVE: begin
                if (timer_q == TRAVEL_LAST) begin
                    timer_d     = '0;
                    cur_floor_d = step_floor;
                    arrive_d    = (step_floor != cur_floor_q);
                    // A call latching on this very edge still stops the car.
                    if (pending_q[step_floor] || rise[step_floor]) begin
                        state_d              = ST_DOOR;
                        clr_mask[step_floor] = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            ST_DOOR: begin
                if (rise[cur_floor_q]) begin
                    // Pressing the call for this floor re-opens the door
                    // instead of queueing another stop here.
                    timer_d               = '0;
                    clr_mask[cur_floor_q] = 1'b1;
                end else if (timer_q == DOOR_LAST) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase

        pending_d = (pending_q | set_mask) & ~clr_mask;
    end

    // -------------------------------------------------------------------------
    // State registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: every register, including the call bits, is reset so an
            // abandoned trip leaves nothing behind once reset is released.
            state_q     <= ST_IDLE;
            pending_q   <= '0;
            cur_floor_q <= '0;
            dir_up_q    <= 1'b1;
            timer_q     <= '0;
            arrive_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            cur_floor_q <= cur_floor_d;
            dir_up_q    <= dir_up_d;
            timer_q     <= timer_d;
            arrive_q    <= arrive_d;
        end
    end

    // Status outputs are decoded from registers only.
    assign pending   = pending_q;
    assign cur_floor = cur_floor_q;
    assign dir_up    = dir_up_q;
    assign moving    = (state_q == ST_MOVE);
    assign door_open = (state_q == ST_DOOR);
    assign arrive    = arrive_q;

endmodule
